// File: rtl/data_ram_wbuf_pkg.sv
// Shared bus widths, request encodings and the byte-merge helper used by the data RAM
// and its write buffer.
package data_ram_wbuf_pkg;

    localparam int DATA_W     = 32;
    localparam int ADDR_BUS_W = 32;
    localparam int SEL_W      = DATA_W / 8;

    localparam logic [DATA_W-1:0] ZERO_WORD     = '0;
    localparam logic              WRITE_ENABLE  = 1'b1;
    localparam logic              WRITE_DISABLE = 1'b0;
    localparam logic              CHIP_ENABLE   = 1'b1;
    localparam logic              CHIP_DISABLE  = 1'b0;

    typedef enum logic [1:0] {
        REQ_IDLE  = 2'd0,
        REQ_LOAD  = 2'd1,
        REQ_STORE = 2'd2
    } req_e;

    // Overlay the enabled bytes of data onto base.
    function automatic logic [DATA_W-1:0] mergeBytes(input logic [DATA_W-1:0] base,
                                                     input logic [DATA_W-1:0] data,
                                                     input logic [SEL_W-1:0]  sel);
        logic [DATA_W-1:0] res;
        res = base;
        for (int b = 0; b < SEL_W; b++) begin
            if (sel[b]) res[8*b +: 8] = data[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/data_ram_wbuf_wbuf.sv
// Store FIFO for the data RAM: holds {word_addr, sel, data} entries and exposes every
// entry, oldest first, so the parent can forward pending stores to loads.
module dmem_wbuf
    import data_ram_wbuf_pkg::*;
#(
    parameter int AW    = 10,
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push_i,
    input  logic [AW-1:0]         push_addr_i,
    input  logic [SEL_W-1:0]      push_sel_i,
    input  logic [DATA_W-1:0]     push_data_i,
    input  logic                  pop_i,
    output logic [AW-1:0]         head_addr_o,
    output logic [SEL_W-1:0]      head_sel_o,
    output logic [DATA_W-1:0]     head_data_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [DEPTH-1:0]      ent_valid_o,
    output logic [DEPTH*AW-1:0]   ent_addr_o,
    output logic [DEPTH*SEL_W-1:0] ent_sel_o,
    output logic [DEPTH*DATA_W-1:0] ent_data_o
);

    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
    logic [PW:0]       count_q, count_d;
    logic [AW-1:0]     entAddr_q [DEPTH];
    logic [SEL_W-1:0]  entSel_q  [DEPTH];
    logic [DATA_W-1:0] entData_q [DEPTH];
    logic              pushOk, popOk;

    assign full_o  = (count_q == (PW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign pushOk  = push_i & ~full_o;
    assign popOk   = pop_i & ~empty_o;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q + {{PW{1'b0}}, pushOk} - {{PW{1'b0}}, popOk};
        if (pushOk) tail_d = tail_q + 1'b1;
        if (popOk)  head_d = head_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry payloads need no reset: validity comes solely from count_q.
    always_ff @(posedge clk) begin
        if (pushOk) begin
            entAddr_q[tail_q] <= push_addr_i;
            entSel_q[tail_q]  <= push_sel_i;
            entData_q[tail_q] <= push_data_i;
        end
    end

    assign head_addr_o = entAddr_q[head_q];
    assign head_sel_o  = entSel_q[head_q];
    assign head_data_o = entData_q[head_q];

    always_comb begin
        logic [PW-1:0] idx;
        idx         = '0;
        ent_valid_o = '0;
        ent_addr_o  = '0;
        ent_sel_o   = '0;
        ent_data_o  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx                          = head_q + PW'(k);
            ent_valid_o[k]               = ((PW+1)'(k) < count_q);
            ent_addr_o[k*AW +: AW]       = entAddr_q[idx];
            ent_sel_o[k*SEL_W +: SEL_W]  = entSel_q[idx];
            ent_data_o[k*DATA_W +: DATA_W] = entData_q[idx];
        end
    end

endmodule

// File: rtl/data_ram_wbuf.sv
// Data-memory responder: stores post into a write buffer and retire into the word array
// when the port is idle; loads read the array with pending stores forwarded on top.
module data_ram_wbuf
    import data_ram_wbuf_pkg::*;
#(
    parameter int ADDR_W     = 10,
    parameter int WBUF_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mem_ce_i,
    input  logic                  mem_we_i,
    input  logic [ADDR_BUS_W-1:0] mem_addr_i,
    input  logic [SEL_W-1:0]      mem_sel_i,
    input  logic [DATA_W-1:0]     mem_data_i,
    output logic [DATA_W-1:0]     mem_data_o,
    output logic                  stall_o
);

    logic [DATA_W-1:0] memArray [0:2**ADDR_W-1];

    logic [ADDR_W-1:0]             wordAddr;
    req_e                          reqKind;
    logic                          push, drain, full, empty;
    logic [ADDR_W-1:0]             headAddr;
    logic [SEL_W-1:0]              headSel;
    logic [DATA_W-1:0]             headData;
    logic [WBUF_DEPTH-1:0]         entValid;
    logic [WBUF_DEPTH*ADDR_W-1:0]  entAddr;
    logic [WBUF_DEPTH*SEL_W-1:0]   entSel;
    logic [WBUF_DEPTH*DATA_W-1:0]  entData;
    logic [DATA_W-1:0]             merged;
    logic                          unusedAddrBits;

    assign wordAddr       = mem_addr_i[ADDR_W+1:2];
    assign unusedAddrBits = ^{mem_addr_i[ADDR_BUS_W-1:ADDR_W+2], mem_addr_i[1:0]};

    always_comb begin
        reqKind = REQ_IDLE;
        if (mem_ce_i == CHIP_ENABLE)
            reqKind = (mem_we_i == WRITE_ENABLE) ? REQ_STORE : REQ_LOAD;
    end

    // A stalled store forces a drain so it is accepted on the following cycle.
    assign stall_o = (reqKind == REQ_STORE) & full;
    assign push    = (reqKind == REQ_STORE) & ~full;
    assign drain   = ((mem_ce_i == CHIP_DISABLE) | stall_o) & ~empty;

    dmem_wbuf #(
        .AW    (ADDR_W),
        .DEPTH (WBUF_DEPTH)
    ) u_wbuf (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push),
        .push_addr_i (wordAddr),
        .push_sel_i  (mem_sel_i),
        .push_data_i (mem_data_i),
        .pop_i       (drain),
        .head_addr_o (headAddr),
        .head_sel_o  (headSel),
        .head_data_o (headData),
        .full_o      (full),
        .empty_o     (empty),
        .ent_valid_o (entValid),
        .ent_addr_o  (entAddr),
        .ent_sel_o   (entSel),
        .ent_data_o  (entData)
    );

    always_ff @(posedge clk) begin
        if (drain) begin
            for (int b = 0; b < SEL_W; b++) begin
                if (headSel[b]) memArray[headAddr][8*b +: 8] <= headData[8*b +: 8];
            end
        end
    end

    // Entries arrive oldest first, so later matches overwrite earlier ones per byte.
    always_comb begin
        merged = memArray[wordAddr];
        for (int k = 0; k < WBUF_DEPTH; k++) begin
            if (entValid[k] && (entAddr[k*ADDR_W +: ADDR_W] == wordAddr))
                merged = mergeBytes(merged, entData[k*DATA_W +: DATA_W], entSel[k*SEL_W +: SEL_W]);
        end
    end

    always_comb begin
        mem_data_o = ZERO_WORD;
        if (rst_n && (reqKind == REQ_LOAD)) mem_data_o = merged;
    end

endmodule

// File: tb/tb_data_ram_wbuf.sv
// Directed bench for data_ram_wbuf: reset, forwarding, byte merge, full-buffer stall,
// load-only blocking of drains and address aliasing.
module tb_data_ram_wbuf;

    logic        clk;
    logic        rst_n;
    logic        memCe;
    logic        memWe;
    logic [31:0] memAddr;
    logic [3:0]  memSel;
    logic [31:0] memDataIn;
    logic [31:0] memDataOut;
    logic        stall;

    int compared;
    int mismatched;

    data_ram_wbuf #(
        .ADDR_W     (10),
        .WBUF_DEPTH (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem_ce_i   (memCe),
        .mem_we_i   (memWe),
        .mem_addr_i (memAddr),
        .mem_sel_i  (memSel),
        .mem_data_i (memDataIn),
        .mem_data_o (memDataOut),
        .stall_o    (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic ce, input logic we, input logic [31:0] addr,
                                 input logic [3:0] sel, input logic [31:0] data);
        memCe     = ce;
        memWe     = we;
        memAddr   = addr;
        memSel    = sel;
        memDataIn = data;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycles(input int n);
        applyStimulus(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        step();
        applyStimulus(1'b1, 1'b0, 32'h0, 4'h0, 32'h0);
        compared++;
        if (memDataOut !== 32'h0) begin
            mismatched++;
            $display("[TB] FAIL reset_load_data: got %h expected %h", memDataOut, 32'h0);
        end
        step();
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            compared++;
            if (stall !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL idle_stall[%0d]: got %b expected 0", i, stall);
            end
            compared++;
            if (memDataOut !== 32'h0) begin
                mismatched++;
                $display("[TB] FAIL idle_data[%0d]: got %h expected %h", i, memDataOut, 32'h0);
            end
            step();
        end
        // Seed two words, then post two stores that a reset must throw away.
        applyStimulus(1'b1, 1'b1, 32'h100, 4'hF, 32'h01010101); step();
        applyStimulus(1'b1, 1'b1, 32'h104, 4'hF, 32'h02020202); step();
        idleCycles(3);
        applyStimulus(1'b1, 1'b0, 32'h100, 4'h0, 32'h0);
        compared++;
        if (memDataOut !== 32'h01010101) begin
            mismatched++;
            $display("[TB] FAIL seed_read: got %h expected %h", memDataOut, 32'h01010101);
        end
        step();
        applyStimulus(1'b1, 1'b1, 32'h100, 4'hF, 32'hAAAAAAAA); step();
        applyStimulus(1'b1, 1'b1, 32'h104, 4'hF, 32'hBBBBBBBB); step();
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        step();
        rst_n = 1'b1;
        idleCycles(2);
        applyStimulus(1'b1, 1'b0, 32'h100, 4'h0, 32'h0);
        compared++;
        if (memDataOut !== 32'h01010101) begin
            mismatched++;
            $display("[TB] FAIL discard_0x100: got %h expected %h", memDataOut, 32'h01010101);
        end
        applyStimulus(1'b1, 1'b0, 32'h104, 4'h0, 32'h0);
        compared++;
        if (memDataOut !== 32'h02020202) begin
            mismatched++;
            $display("[TB] FAIL discard_0x104: got %h expected %h", memDataOut, 32'h02020202);
        end
        step();
    endtask

    task automatic test_forward();
        idleCycles(4);
        applyStimulus(1'b1, 1'b1, 32'h40, 4'hF, 32'hDEADBEEF); step();
        applyStimulus(1'b1, 1'b0, 32'h40, 4'h0, 32'h0);
        compared++;
        if (memDataOut !== 32'hDEADBEEF) begin
            mismatched++;
            $display("[TB] FAIL fwd_load: got %h expected %h", memDataOut, 32'hDEADBEEF);
        end
        step();
        idleCycles(1);
        applyStimulus(1'b1, 1'b0, 32'h40, 4'h0, 32'h0);
        compared++;
        if (memDataOut !== 32'hDEADBEEF) begin
            mismatched++;
            $display("[TB] FAIL array_load: got %h expected %h", memDataOut, 32'hDEADBEEF);
        end
        step();
    endtask

    task automatic test_byte_merge();
        idleCycles(4);
        applyStimulus(1'b1, 1'b1, 32'h10, 4'hF, 32'h11223344); step();
        idleCycles(2);
        applyStimulus(1'b1, 1'b1, 32'h10, 4'b0001, 32'h000000AA); step();
        applyStimulus(1'b1, 1'b1, 32'h10, 4'b0100, 32'h00BB0000); step();
        applyStimulus(1'b1, 1'b0, 32'h10, 4'h0, 32'h0);
        compared++;
        if (memDataOut !== 32'h11BB33AA) begin
            mismatched++;
            $display("[TB] FAIL merge_fwd: got %h expected %h", memDataOut, 32'h11BB33AA);
        end
        step();
        idleCycles(3);
        applyStimulus(1'b1, 1'b0, 32'h10, 4'h0, 32'h0);
        compared++;
        if (memDataOut !== 32'h11BB33AA) begin
            mismatched++;
            $display("[TB] FAIL merge_array: got %h expected %h", memDataOut, 32'h11BB33AA);
        end
        step();
    endtask

    task automatic test_back_to_back();
        idleCycles(4);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b1, 32'h200 + 32'(4*i), 4'hF, 32'hC0DE0000 + 32'(i));
            compared++;
            if (stall !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL fill_stall[%0d]: got %b expected 0", i, stall);
            end
            step();
        end
        applyStimulus(1'b1, 1'b1, 32'h210, 4'hF, 32'hC0DE0004);
        compared++;
        if (stall !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL fifth_stall: got %b expected 1", stall);
        end
        step();
        compared++;
        if (stall !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL fifth_release: got %b expected 0", stall);
        end
        step();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'b0, 32'h200 + 32'(4*i), 4'h0, 32'h0);
            compared++;
            if (memDataOut !== 32'hC0DE0000 + 32'(i)) begin
                mismatched++;
                $display("[TB] FAIL readback[%0d]: got %h expected %h", i, memDataOut, 32'hC0DE0000 + 32'(i));
            end
            step();
        end
    endtask

    task automatic test_load_blocks_drain();
        // Buffer is left full by the previous scenario: 0x204..0x210 pending.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 1'b0, 32'h200 + 32'(4*(i % 5)), 4'h0, 32'h0);
            compared++;
            if (stall !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL load_stall[%0d]: got %b expected 0", i, stall);
            end
            compared++;
            if (memDataOut !== 32'hC0DE0000 + 32'(i % 5)) begin
                mismatched++;
                $display("[TB] FAIL load_data[%0d]: got %h expected %h", i, memDataOut, 32'hC0DE0000 + 32'(i % 5));
            end
            step();
        end
        compared++;
        if (dut.u_wbuf.count_q !== 3'd4) begin
            mismatched++;
            $display("[TB] FAIL count_after_loads: got %0d expected 4", dut.u_wbuf.count_q);
        end
        idleCycles(1);
        compared++;
        if (dut.u_wbuf.count_q !== 3'd3) begin
            mismatched++;
            $display("[TB] FAIL count_after_idle: got %0d expected 3", dut.u_wbuf.count_q);
        end
    endtask

    task automatic test_alias();
        idleCycles(5);
        applyStimulus(1'b1, 1'b1, 32'h00000004, 4'hF, 32'h12345678); step();
        applyStimulus(1'b1, 1'b1, 32'h00001006, 4'hF, 32'h9ABCDEF0); step();
        applyStimulus(1'b1, 1'b0, 32'h00000007, 4'h0, 32'h0);
        compared++;
        if (memDataOut !== 32'h9ABCDEF0) begin
            mismatched++;
            $display("[TB] FAIL alias_fwd: got %h expected %h", memDataOut, 32'h9ABCDEF0);
        end
        step();
        idleCycles(3);
        applyStimulus(1'b1, 1'b0, 32'h00000004, 4'h0, 32'h0);
        compared++;
        if (memDataOut !== 32'h9ABCDEF0) begin
            mismatched++;
            $display("[TB] FAIL alias_array: got %h expected %h", memDataOut, 32'h9ABCDEF0);
        end
        step();
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst_n      = 1'b0;
        memCe      = 1'b0;
        memWe      = 1'b0;
        memAddr    = 32'h0;
        memSel     = 4'h0;
        memDataIn  = 32'h0;
        test_reset();
        test_forward();
        test_byte_merge();
        test_back_to_back();
        test_load_blocks_drain();
        test_alias();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
